// File: rtl/modulo_escalonador_quantum.sv
// Quantum scheduler: alternates SO and user process, raising timer or HALT interrupts.
// Latency: pulses and saved PCs are registered and appear one edge after the triggering cycle.
// Backpressure: none; loop_enable=0 freezes every register, including the FSM state.
module modulo_escalonador_quantum #(
  parameter int          ADDR_WIDTH      = 13,
  parameter int          QUANTUM_WIDTH   = 16,
  parameter int unsigned QUANTUM_DEFAULT = 1000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     loop_enable,
  input  logic                     os_jump,
  input  logic                     halt_req,
  input  logic [ADDR_WIDTH-1:0]    pc_atual,
  input  logic [ADDR_WIDTH-1:0]    pc_proximo,
  input  logic                     quantum_wr,
  input  logic [QUANTUM_WIDTH-1:0] quantum_in,
  output logic                     int_clk,
  output logic                     halt,
  output logic [ADDR_WIDTH-1:0]    pc_retorno_so,
  output logic [ADDR_WIDTH-1:0]    pc_processo,
  output logic                     modo_usuario,
  output logic [QUANTUM_WIDTH-1:0] quantum_restante,
  output logic [7:0]               trocas
);

  typedef enum logic [1:0] {
    ST_SO          = 2'd0,
    ST_USUARIO     = 2'd1,
    ST_INTERRUPCAO = 2'd2
  } estado_t;

  estado_t                  r_estado;
  estado_t                  w_prox_estado;
  logic                     w_inicia;
  logic                     w_halt_evt;
  logic                     w_expira;
  logic                     w_fim_irq;
  logic [QUANTUM_WIDTH-1:0] r_quantum;
  logic [QUANTUM_WIDTH-1:0] r_contador;
  logic [ADDR_WIDTH-1:0]    r_pc_retorno;
  logic [ADDR_WIDTH-1:0]    r_pc_processo;
  logic                     r_halt;
  logic                     r_int_clk;
  logic [7:0]               r_trocas;

  // Next-state and event decode; HALT takes priority over quantum expiry.
  always_comb begin
    w_prox_estado = r_estado;
    w_inicia      = 1'b0;
    w_halt_evt    = 1'b0;
    w_expira      = 1'b0;
    w_fim_irq     = 1'b0;
    case (r_estado)
      ST_SO: begin
        if (os_jump) begin
          w_inicia      = 1'b1;
          w_prox_estado = ST_USUARIO;
        end
      end
      ST_USUARIO: begin
        if (halt_req) begin
          w_halt_evt    = 1'b1;
          w_prox_estado = ST_INTERRUPCAO;
        end else if (r_contador == QUANTUM_WIDTH'(1)) begin
          w_expira      = 1'b1;
          w_prox_estado = ST_INTERRUPCAO;
        end
      end
      ST_INTERRUPCAO: begin
        w_fim_irq     = 1'b1;
        w_prox_estado = ST_SO;
      end
      default: w_prox_estado = ST_SO;
    endcase
  end

  // State register; advances only on enabled edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= ST_SO;
    end else if (loop_enable) begin
      r_estado <= w_prox_estado;
    end
  end

  // Quantum register: zero writes are dropped, a running countdown keeps its own copy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_quantum <= QUANTUM_WIDTH'(QUANTUM_DEFAULT);
    end else if (loop_enable && quantum_wr && (quantum_in != '0)) begin
      r_quantum <= quantum_in;
    end
  end

  // Countdown: loaded on process start, decremented on every user-mode edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_contador <= '0;
    end else if (loop_enable) begin
      if (w_inicia) begin
        r_contador <= r_quantum;
      end else if (r_estado == ST_USUARIO) begin
        r_contador <= r_contador - QUANTUM_WIDTH'(1);
      end
    end
  end

  // Resume addresses: SO return point on start, process PC on interrupt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc_retorno  <= '0;
      r_pc_processo <= '0;
    end else if (loop_enable) begin
      if (w_inicia) begin
        r_pc_retorno <= pc_atual + ADDR_WIDTH'(1);
      end
      if (w_halt_evt) begin
        r_pc_processo <= pc_atual;
      end else if (w_expira) begin
        r_pc_processo <= pc_proximo;
      end
    end
  end

  // Interrupt pulses: set on entering INTERRUPCAO, cleared on the edge that leaves it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_halt    <= 1'b0;
      r_int_clk <= 1'b0;
    end else if (loop_enable) begin
      if (w_fim_irq) begin
        r_halt    <= 1'b0;
        r_int_clk <= 1'b0;
      end else begin
        if (w_halt_evt) r_halt    <= 1'b1;
        if (w_expira)   r_int_clk <= 1'b1;
      end
    end
  end

  // Context-switch counter, saturating at 255.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_trocas <= '0;
    end else if (loop_enable && w_fim_irq && (r_trocas != 8'hFF)) begin
      r_trocas <= r_trocas + 8'd1;
    end
  end

  assign int_clk          = r_int_clk;
  assign halt             = r_halt;
  assign pc_retorno_so    = r_pc_retorno;
  assign pc_processo      = r_pc_processo;
  assign modo_usuario     = (r_estado == ST_USUARIO);
  assign quantum_restante = r_contador;
  assign trocas           = r_trocas;

endmodule

// File: tb/tb_modulo_escalonador_quantum.sv
// Bench for the quantum scheduler: behavioural model plus directed scenarios.
// Latency: outputs compared on every falling edge against the model.
// Backpressure: n/a; loop_enable freeze exercised directly.
module tb_modulo_escalonador_quantum;
  localparam int AW = 13;
  localparam int QW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          loop_enable = 1'b0;
  logic          os_jump = 1'b0;
  logic          halt_req = 1'b0;
  logic [AW-1:0] pc_atual = '0;
  logic [AW-1:0] pc_proximo = '0;
  logic          quantum_wr = 1'b0;
  logic [QW-1:0] quantum_in = '0;
  logic          int_clk;
  logic          halt;
  logic [AW-1:0] pc_retorno_so;
  logic [AW-1:0] pc_processo;
  logic          modo_usuario;
  logic [QW-1:0] quantum_restante;
  logic [7:0]    trocas;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: a process is either running (m_user) or a pending interrupt kind
  // (0 none, 1 timer, 2 halt) is being signalled; otherwise the OS runs.
  bit m_user;
  int m_kind;
  int m_left;
  int m_q;
  int m_ret;
  int m_proc;
  int m_sw;

  modulo_escalonador_quantum dut (
    .clock(clock), .reset_n(reset_n), .loop_enable(loop_enable),
    .os_jump(os_jump), .halt_req(halt_req), .pc_atual(pc_atual),
    .pc_proximo(pc_proximo), .quantum_wr(quantum_wr), .quantum_in(quantum_in),
    .int_clk(int_clk), .halt(halt), .pc_retorno_so(pc_retorno_so),
    .pc_processo(pc_processo), .modo_usuario(modo_usuario),
    .quantum_restante(quantum_restante), .trocas(trocas)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_pulse(input string name);
    int n = 0;
    while (!(int_clk || halt) && n < 300) begin
      step();
      n++;
    end
    check(name, 32'(int_clk | halt), 32'd1);
  endtask

  // Behavioural model of the scheduler rules.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_user = 1'b0; m_kind = 0; m_left = 0; m_q = 1000;
      m_ret = 0; m_proc = 0; m_sw = 0;
    end else if (loop_enable) begin
      if (m_kind != 0) begin
        m_kind = 0;
        m_sw = (m_sw < 255) ? m_sw + 1 : 255;
      end else if (m_user) begin
        m_left = m_left - 1;
        if (halt_req) begin
          m_proc = int'(pc_atual); m_kind = 2; m_user = 1'b0;
        end else if (m_left == 0) begin
          m_proc = int'(pc_proximo); m_kind = 1; m_user = 1'b0;
        end
      end else if (os_jump) begin
        m_ret = (int'(pc_atual) + 1) % (1 << AW);
        m_left = m_q;
        m_user = 1'b1;
      end
      if (quantum_wr && quantum_in != 0) m_q = int'(quantum_in);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_int_clk", 32'(int_clk), 32'(m_kind == 1));
      check("m_halt", 32'(halt), 32'(m_kind == 2));
      check("m_modo", 32'(modo_usuario), 32'(m_user));
      check("m_pc_ret", 32'(pc_retorno_so), 32'(m_ret));
      check("m_pc_proc", 32'(pc_processo), 32'(m_proc));
      check("m_restante", 32'(quantum_restante), 32'(m_left));
      check("m_trocas", 32'(trocas), 32'(m_sw));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    step(); step();
    check("rst_trocas", 32'(trocas), 32'd0);
    check("rst_restante", 32'(quantum_restante), 32'd0);
    check("rst_modo", 32'(modo_usuario), 32'd0);
    check("rst_pulses", 32'(int_clk | halt), 32'd0);
    reset_n = 1'b1;
    loop_enable = 1'b1;
    chk_en = 1'b1;

    // Timer expiry with quantum 3
    quantum_wr = 1'b1; quantum_in = 16'd3;
    step();
    quantum_wr = 1'b0; os_jump = 1'b1; pc_atual = 13'h0010; pc_proximo = 13'h0ABC;
    step();
    os_jump = 1'b0;
    check("t1_ret", 32'(pc_retorno_so), 32'h11);
    n = 0;
    while (modo_usuario && n < 20) begin
      n++;
      step();
    end
    check("t1_user_cycles", 32'(n), 32'd3);
    check("t1_int_clk", 32'(int_clk), 32'd1);
    check("t1_halt", 32'(halt), 32'd0);
    check("t1_pc_proc", 32'(pc_processo), 32'h0ABC);
    step();
    check("t1_int_drop", 32'(int_clk), 32'd0);
    check("t1_trocas", 32'(trocas), 32'd1);

    // HALT on the 5th user cycle with quantum 100
    quantum_wr = 1'b1; quantum_in = 16'd100;
    step();
    quantum_wr = 1'b0; os_jump = 1'b1; pc_atual = 13'h0100;
    step();
    os_jump = 1'b0;
    repeat (4) step();
    halt_req = 1'b1; pc_atual = 13'h0234;
    step();
    halt_req = 1'b0;
    check("t2_halt", 32'(halt), 32'd1);
    check("t2_int_clk", 32'(int_clk), 32'd0);
    check("t2_pc_proc", 32'(pc_processo), 32'h0234);
    check("t2_restante", 32'(quantum_restante), 32'd95);
    step();
    check("t2_halt_drop", 32'(halt), 32'd0);
    check("t2_restante_held", 32'(quantum_restante), 32'd95);
    check("t2_trocas", 32'(trocas), 32'd2);

    // HALT coinciding with expiry, quantum 2
    quantum_wr = 1'b1; quantum_in = 16'd2;
    step();
    quantum_wr = 1'b0; os_jump = 1'b1;
    step();
    os_jump = 1'b0;
    step();
    halt_req = 1'b1; pc_atual = 13'h0055;
    step();
    halt_req = 1'b0;
    check("t3_halt", 32'(halt), 32'd1);
    check("t3_int_clk", 32'(int_clk), 32'd0);
    step();
    check("t3_trocas", 32'(trocas), 32'd3);

    // Zero write ignored, PC wrap, write during countdown has no effect
    quantum_wr = 1'b1; quantum_in = 16'd0;
    step();
    quantum_wr = 1'b0; os_jump = 1'b1; pc_atual = 13'h1FFF;
    step();
    os_jump = 1'b0;
    check("t4_wrap", 32'(pc_retorno_so), 32'd0);
    check("t4_q_kept", 32'(quantum_restante), 32'd2);
    quantum_wr = 1'b1; quantum_in = 16'd7;
    step();
    quantum_wr = 1'b0;
    check("t4_cd_unaffected", 32'(quantum_restante), 32'd1);
    step();
    check("t4_int_clk", 32'(int_clk), 32'd1);
    step();
    check("t4_trocas", 32'(trocas), 32'd4);

    // Freeze mid-USUARIO
    quantum_wr = 1'b1; quantum_in = 16'd50;
    step();
    quantum_wr = 1'b0; os_jump = 1'b1; pc_atual = 13'h0040;
    step();
    os_jump = 1'b0;
    step(); step();
    loop_enable = 1'b0; quantum_wr = 1'b1; quantum_in = 16'd5; halt_req = 1'b1; os_jump = 1'b1;
    repeat (10) begin
      step();
      check("t5_frozen_q", 32'(quantum_restante), 32'd48);
      check("t5_frozen_modo", 32'(modo_usuario), 32'd1);
    end
    loop_enable = 1'b1; quantum_wr = 1'b0; halt_req = 1'b0; os_jump = 1'b0;
    step();
    check("t5_resume", 32'(quantum_restante), 32'd47);
    wait_pulse("t5_wait_int");
    check("t5_int_clk", 32'(int_clk), 32'd1);

    // Asynchronous reset during INTERRUPCAO
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_int", 32'(int_clk), 32'd0);
    check("t5_rst_halt", 32'(halt), 32'd0);
    check("t5_rst_modo", 32'(modo_usuario), 32'd0);
    check("t5_rst_trocas", 32'(trocas), 32'd0);
    check("t5_rst_proc", 32'(pc_processo), 32'd0);
    check("t5_rst_q", 32'(quantum_restante), 32'd0);
    step(); step();
    reset_n = 1'b1;
    os_jump = 1'b1; pc_atual = 13'h0000;
    step();
    os_jump = 1'b0;
    check("t5_default_q", 32'(quantum_restante), 32'd1000);
    check("t5_ret", 32'(pc_retorno_so), 32'd1);
    halt_req = 1'b1; pc_atual = 13'h0077;
    step();
    halt_req = 1'b0;
    check("t5_halt", 32'(halt), 32'd1);
    check("t5_q999", 32'(quantum_restante), 32'd999);
    step();
    check("t5_trocas", 32'(trocas), 32'd1);

    // Reset during USUARIO: no pulse afterwards
    os_jump = 1'b1;
    step();
    os_jump = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t5u_rst_modo", 32'(modo_usuario), 32'd0);
    step();
    reset_n = 1'b1;
    repeat (5) step();
    check("t5u_no_pulse", 32'(int_clk | halt), 32'd0);

    // Saturation: 300 timer switches with quantum 1
    quantum_wr = 1'b1; quantum_in = 16'd1;
    step();
    quantum_wr = 1'b0; os_jump = 1'b1;
    pulses = 0;
    repeat (900) begin
      step();
      if (int_clk) pulses++;
    end
    os_jump = 1'b0;
    check("t6_pulses", 32'(pulses), 32'd300);
    check("t6_trocas", 32'(trocas), 32'd255);
    step(); step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/modulo_escalonador_quantum.md
MODULO_ESCALONADOR_QUANTUM -- requirements
Module: modulo_escalonador_quantum

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, SHALL set the PC address width.
REQ-002 Parameter QUANTUM_WIDTH, default 16, SHALL set the quantum counter width.
REQ-003 Parameter QUANTUM_DEFAULT, default 1000, SHALL be the quantum loaded at reset; it is nonzero.
REQ-004 clock  in  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 loop_enable  in  1  external run switch; 0 freezes all state.
REQ-007 os_jump  in  1  SO executes os_jump_to this cycle; starts the user process.
REQ-008 halt_req  in  1  HALT decoded in the current user instruction.
REQ-009 pc_atual  in  ADDR_WIDTH  address of the current instruction.
REQ-010 pc_proximo  in  ADDR_WIDTH  next PC computed by the datapath.
REQ-011 quantum_wr  in  1  load strobe for the quantum register.
REQ-012 quantum_in  in  QUANTUM_WIDTH  new quantum value.
REQ-013 int_clk  out  1  timer interrupt pulse to the PC module.
REQ-014 halt  out  1  HALT interrupt pulse to the PC module.
REQ-015 pc_retorno_so  out  ADDR_WIDTH  SO resume address.
REQ-016 pc_processo  out  ADDR_WIDTH  saved user-process resume address.
REQ-017 modo_usuario  out  1  1 while in state USUARIO.
REQ-018 quantum_restante  out  QUANTUM_WIDTH  live countdown value.
REQ-019 trocas  out  8  context-switch count, saturating at 255.

Function
REQ-020 The FSM SHALL have three states: SO, USUARIO and INTERRUPCAO.
REQ-021 With loop_enable=0, every register, including FSM state, SHALL hold its value, and quantum_wr SHALL be ignored.
REQ-022 A quantum_wr with quantum_in≠0 SHALL update the quantum register in any state.
- A quantum_in=0 write SHALL be ignored.
- The write SHALL NOT affect a countdown in progress.
REQ-023 SO with os_jump=1 SHALL, at the edge:
- set pc_retorno_so ← pc_atual+1 mod 2^ADDR_WIDTH;
- load the counter with the quantum register;
- go to USUARIO.
REQ-024 In SO, halt_req SHALL be ignored.
REQ-025 In USUARIO, os_jump SHALL be ignored, and each enabled edge SHALL decrement the counter by 1.
REQ-026 USUARIO with halt_req=1 SHALL, at the edge:
- set pc_processo ← pc_atual;
- set halt ← 1;
- go to INTERRUPCAO.
REQ-027 USUARIO with halt_req=0 and counter=1 SHALL, at the edge:
- set pc_processo ← pc_proximo;
- set int_clk ← 1;
- set the counter to 0;
- go to INTERRUPCAO.
REQ-028 A quantum of Q SHALL give exactly Q cycles in USUARIO before int_clk is asserted.
REQ-029 When halt_req and quantum expiry coincide, halt SHALL win, and int_clk SHALL stay 0.
REQ-030 INTERRUPCAO SHALL last exactly one enabled cycle, with the selected pulse high.
- The next edge SHALL clear both pulses, increment trocas (saturating) and return to SO.
REQ-031 halt and int_clk SHALL be registered, mutually exclusive, and never high outside INTERRUPCAO.
REQ-032 If loop_enable drops during INTERRUPCAO, the pulse SHALL be held until loop_enable returns and one enabled edge completes.

Reset
REQ-033 With reset_n=0, the block SHALL immediately, without waiting for a clock edge, set:
- state SO;
- halt=0, int_clk=0, modo_usuario=0;
- pc_retorno_so=0, pc_processo=0;
- counter=0, trocas=0;
- quantum register=QUANTUM_DEFAULT.
REQ-034 Reset asserted mid-USUARIO or mid-INTERRUPCAO SHALL abort the operation, and no pulse SHALL be emitted afterwards.
REQ-035 After reset_n rises, the first transition SHALL occur only on a qualifying edge.

Verification
REQ-036 Timer: quantum_wr with quantum_in=3; os_jump with pc_atual=0x0010 → pc_retorno_so=0x0011, modo_usuario high for 3 cycles, then int_clk high for 1 cycle, pc_processo=pc_proximo sampled, trocas=1.
REQ-037 HALT: quantum=100; halt_req on the 5th user cycle with pc_atual=0x0234 → halt pulse for 1 cycle, pc_processo=0x0234, int_clk=0, quantum_restante=95 held.
REQ-038 Collision: quantum=2; halt_req on the 2nd user cycle → halt=1, int_clk=0.
REQ-039 Wrap and zero write: os_jump with pc_atual=0x1FFF → pc_retorno_so=0x0000; quantum_wr with quantum_in=0 → quantum register unchanged.
REQ-040 Freeze and reset: loop_enable=0 for 10 cycles mid-USUARIO → quantum_restante constant; reset_n=0 asynchronously mid-INTERRUPCAO → pulses drop at once, state SO, trocas=0.
REQ-041 Saturation: 300 consecutive timer switches with quantum=1 → trocas=255.
